// File: rtl/echo_frame_sequencer_if.sv
// Control bundle between the echo-frame sequencer and the echo-cancellation datapath.
// The master side is the sequencer; the slave side is the datapath and the frame timing source.
interface echo_frame_sequencer_if #(
   parameter int unsigned CW = 13
);
   logic          run;
   logic [CW-1:0] sampling_cycle_counter;
   logic          ready_conv;
   logic          ready_lag;
   logic          clear_err;
   logic          enable_conv;
   logic          enable_lag;
   logic          enable_out;
   logic          enable_cancel;
   logic          lag_sampling_en;
   logic [15:0]   frame_count;
   logic          timeout_err;
   logic [1:0]    err_stage;
   logic          overrun_err;
   logic          busy;

   modport master (
      input  run, sampling_cycle_counter, ready_conv, ready_lag, clear_err,
      output enable_conv, enable_lag, enable_out, enable_cancel, lag_sampling_en,
      output frame_count, timeout_err, err_stage, overrun_err, busy
   );

   modport slave (
      output run, sampling_cycle_counter, ready_conv, ready_lag, clear_err,
      input  enable_conv, enable_lag, enable_out, enable_cancel, lag_sampling_en,
      input  frame_count, timeout_err, err_stage, overrun_err, busy
   );
endinterface

// File: rtl/echo_frame_sequencer.sv
// Per-frame enable sequencer for the echo-cancellation chain: handshake-driven conv/lag stages,
// timeout and overrun detection, cancel-delay and warm-up gating. All outputs are registered.
module echo_frame_sequencer #(
   parameter int unsigned PULSE_LEN     = 4,
   parameter int unsigned CONV_TIMEOUT  = 64,
   parameter int unsigned LAG_TIMEOUT   = 1024,
   parameter int unsigned CANCEL_DELAY  = 2500,
   parameter int unsigned WARMUP_FRAMES = 2,
   parameter int unsigned CW            = 13
) (
   input logic                   clk_operation,
   input logic                   rst,
   echo_frame_sequencer_if.master bus
);

   localparam int unsigned MaxTo  = (CONV_TIMEOUT > LAG_TIMEOUT) ? CONV_TIMEOUT : LAG_TIMEOUT;
   localparam int unsigned WaitW  = $clog2(MaxTo + 1);
   localparam int unsigned PulseW = $clog2(PULSE_LEN + 1);
   localparam int unsigned DelayW = $clog2(CANCEL_DELAY + 1);
   localparam int unsigned WarmW  = $clog2(WARMUP_FRAMES + 2);

   localparam logic [PulseW-1:0] PulseLast  = PulseW'(PULSE_LEN - 1);
   localparam logic [WaitW-1:0]  ConvLimit  = WaitW'(CONV_TIMEOUT);
   localparam logic [WaitW-1:0]  LagLimit   = WaitW'(LAG_TIMEOUT);
   localparam logic [DelayW-1:0] DelayLast  = DelayW'(CANCEL_DELAY - 1);
   localparam logic [WarmW-1:0]  WarmTarget = WarmW'(WARMUP_FRAMES);

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StConvPulse = 3'd1;
   localparam logic [2:0] StConvWait  = 3'd2;
   localparam logic [2:0] StLagPulse  = 3'd3;
   localparam logic [2:0] StLagWait   = 3'd4;
   localparam logic [2:0] StFrameDone = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [PulseW-1:0] pulse_q, pulse_d;
   logic [WaitW-1:0]  wait_q, wait_d, wait_inc;
   logic [DelayW-1:0] delay_q, delay_d;
   logic [WarmW-1:0]  warm_q, warm_d;
   logic              conv_q, conv_d;
   logic              lag_q, lag_d;
   logic              out_q, out_d;
   logic              cancel_q, cancel_d;
   logic              lse_q, lse_d;
   logic [15:0]       fc_q, fc_d;
   logic              to_q, to_d;
   logic [1:0]        stage_q, stage_d;
   logic              ov_q, ov_d;
   logic              busy_q, busy_d;
   logic              frame_start;

   assign frame_start = (bus.sampling_cycle_counter == {CW{1'b0}});
   assign wait_inc    = wait_q + WaitW'(1);

   always_comb begin
      state_d  = state_q;
      pulse_d  = pulse_q;
      wait_d   = wait_q;
      delay_d  = delay_q;
      warm_d   = warm_q;
      conv_d   = conv_q;
      lag_d    = lag_q;
      out_d    = out_q;
      cancel_d = cancel_q;
      lse_d    = lse_q;
      fc_d     = fc_q;
      to_d     = to_q;
      stage_d  = stage_q;
      ov_d     = ov_q;

      // Clear is applied first so that an error firing in the same cycle overrides it.
      if (bus.clear_err) begin
         to_d    = 1'b0;
         stage_d = 2'b00;
         ov_d    = 1'b0;
      end

      if (!bus.run) begin
         state_d  = StIdle;
         pulse_d  = '0;
         wait_d   = '0;
         delay_d  = '0;
         warm_d   = '0;
         conv_d   = 1'b0;
         lag_d    = 1'b0;
         out_d    = 1'b0;
         cancel_d = 1'b0;
         lse_d    = 1'b0;
      end else begin
         if (state_q != StIdle && frame_start) begin
            ov_d = 1'b1;
         end

         case (state_q)
            StIdle: begin
               if (frame_start) begin
                  state_d = StConvPulse;
                  conv_d  = 1'b1;
                  pulse_d = '0;
               end
            end
            StConvPulse: begin
               if (pulse_q == PulseLast) begin
                  state_d = StConvWait;
                  conv_d  = 1'b0;
                  wait_d  = '0;
               end else begin
                  pulse_d = pulse_q + PulseW'(1);
               end
            end
            StConvWait: begin
               if (bus.ready_conv) begin
                  state_d = StLagPulse;
                  lag_d   = 1'b1;
                  pulse_d = '0;
               end else if (wait_inc == ConvLimit) begin
                  state_d = StIdle;
                  wait_d  = '0;
                  to_d    = 1'b1;
                  stage_d = 2'b01;
               end else begin
                  wait_d = wait_inc;
               end
            end
            StLagPulse: begin
               if (pulse_q == PulseLast) begin
                  state_d = StLagWait;
                  lag_d   = 1'b0;
                  wait_d  = '0;
               end else begin
                  pulse_d = pulse_q + PulseW'(1);
               end
            end
            StLagWait: begin
               if (bus.ready_lag) begin
                  state_d = StFrameDone;
               end else if (wait_inc == LagLimit) begin
                  state_d = StIdle;
                  wait_d  = '0;
                  to_d    = 1'b1;
                  stage_d = 2'b10;
               end else begin
                  wait_d = wait_inc;
               end
            end
            StFrameDone: begin
               state_d = StIdle;
               fc_d    = fc_q + 16'd1;
               out_d   = 1'b1;
               if (warm_q != WarmTarget) begin
                  warm_d = warm_q + WarmW'(1);
               end
            end
            default: state_d = StIdle;
         endcase

         // Cancel delay runs from the enable_out rise, independent of the frame FSM.
         if (out_q && !cancel_q) begin
            if (delay_q == DelayLast) begin
               cancel_d = 1'b1;
            end else begin
               delay_d = delay_q + DelayW'(1);
            end
         end

         if (warm_q == WarmTarget) begin
            lse_d = 1'b1;
         end
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_operation or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         pulse_q  <= '0;
         wait_q   <= '0;
         delay_q  <= '0;
         warm_q   <= '0;
         conv_q   <= 1'b0;
         lag_q    <= 1'b0;
         out_q    <= 1'b0;
         cancel_q <= 1'b0;
         lse_q    <= 1'b0;
         fc_q     <= 16'd0;
         to_q     <= 1'b0;
         stage_q  <= 2'b00;
         ov_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pulse_q  <= pulse_d;
         wait_q   <= wait_d;
         delay_q  <= delay_d;
         warm_q   <= warm_d;
         conv_q   <= conv_d;
         lag_q    <= lag_d;
         out_q    <= out_d;
         cancel_q <= cancel_d;
         lse_q    <= lse_d;
         fc_q     <= fc_d;
         to_q     <= to_d;
         stage_q  <= stage_d;
         ov_q     <= ov_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.enable_conv     = conv_q;
   assign bus.enable_lag      = lag_q;
   assign bus.enable_out      = out_q;
   assign bus.enable_cancel   = cancel_q;
   assign bus.lag_sampling_en = lse_q;
   assign bus.frame_count     = fc_q;
   assign bus.timeout_err     = to_q;
   assign bus.err_stage       = stage_q;
   assign bus.overrun_err     = ov_q;
   assign bus.busy            = busy_q;

endmodule

// File: tb/tb_echo_frame_sequencer.sv
// Randomized bench for echo_frame_sequencer; expectations come from per-frame event timing
// derived from the frame rules, checked on every falling edge.
module tb_echo_frame_sequencer;

   localparam int unsigned PulseLen    = 4;
   localparam int unsigned ConvTo      = 16;
   localparam int unsigned LagTo       = 128;
   localparam int unsigned CancelDelay = 50;
   localparam int unsigned Warmup      = 2;
   localparam int unsigned Cw          = 13;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   echo_frame_sequencer_if #(.CW(Cw)) bus ();

   echo_frame_sequencer #(
      .PULSE_LEN     (PulseLen),
      .CONV_TIMEOUT  (ConvTo),
      .LAG_TIMEOUT   (LagTo),
      .CANCEL_DELAY  (CancelDelay),
      .WARMUP_FRAMES (Warmup),
      .CW            (Cw)
   ) dut (
      .clk_operation (clk),
      .rst           (rst),
      .bus           (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference state: frame/warm-up counts, event cycles and sticky flags.
   int       exp_fc;
   int       out_rise;
   int       warm;
   int       warm_at;
   bit       exp_to;
   bit [1:0] exp_stage;
   bit       exp_ov;
   bit       exp_busy;
   bit       exp_conv;
   bit       exp_lag;
   int       ov_rate = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic model_reset();
      exp_fc = 0; out_rise = -1; warm = 0; warm_at = -1;
      exp_to = 0; exp_stage = 2'b00; exp_ov = 0;
      exp_busy = 0; exp_conv = 0; exp_lag = 0;
   endtask

   task automatic check_all();
      chk_eq("enable_conv", 32'(bus.enable_conv), 32'(exp_conv));
      chk_eq("enable_lag", 32'(bus.enable_lag), 32'(exp_lag));
      chk_eq("enable_out", 32'(bus.enable_out), 32'(out_rise >= 0));
      chk_eq("enable_cancel", 32'(bus.enable_cancel),
             32'(out_rise >= 0 && cyc >= out_rise + int'(CancelDelay)));
      chk_eq("lag_sampling_en", 32'(bus.lag_sampling_en), 32'(warm_at >= 0 && cyc > warm_at));
      chk_eq("frame_count", 32'(bus.frame_count), 32'(exp_fc & 16'hffff));
      chk_eq("timeout_err", 32'(bus.timeout_err), 32'(exp_to));
      chk_eq("err_stage", 32'(bus.err_stage), 32'(exp_stage));
      chk_eq("overrun_err", 32'(bus.overrun_err), 32'(exp_ov));
      chk_eq("busy", 32'(bus.busy), 32'(exp_busy));
   endtask

   // Advance one clock; apply the effects of the inputs that were present at the rising edge.
   task automatic step();
      bit c, o, r;
      c = bus.clear_err;
      r = !bus.run;
      o = bus.run && (bus.sampling_cycle_counter == 0) && exp_busy;
      @(negedge clk);
      cyc++;
      if (c) begin exp_to = 0; exp_stage = 2'b00; exp_ov = 0; end
      if (o) exp_ov = 1;
      if (r) begin
         out_rise = -1; warm = 0; warm_at = -1;
         exp_busy = 0; exp_conv = 0; exp_lag = 0;
      end
   endtask

   function automatic logic [Cw-1:0] rand_phase();
      return Cw'($urandom_range(8191, 1));
   endfunction

   task automatic drive_busy();
      bus.ready_conv = 1'b0;
      bus.ready_lag  = 1'b0;
      bus.clear_err  = ($urandom_range(15) == 0);
      if (ov_rate != 0 && $urandom_range(ov_rate - 1) == 0) bus.sampling_cycle_counter = '0;
      else bus.sampling_cycle_counter = rand_phase();
   endtask

   task automatic idle_tick();
      bus.ready_conv = 1'b0;
      bus.ready_lag  = 1'b0;
      bus.clear_err  = ($urandom_range(7) == 0);
      bus.sampling_cycle_counter = rand_phase();
      step();
      check_all();
   endtask

   task automatic run_low(input int n);
      bus.run = 1'b0;
      for (int i = 0; i < n; i++) idle_tick();
      bus.run = 1'b1;
   endtask

   // One frame from an idle sequencer. cd/ld: wait edge (1-based) carrying ready, 0 = never.
   // abort_j: lag-wait edge at which run drops, 0 = none.
   task automatic frame(input int cd, input int ld, input int abort_j);
      bus.run = 1'b1;
      bus.sampling_cycle_counter = '0;
      bus.ready_conv = 1'b0;
      bus.ready_lag  = 1'b0;
      for (int k = 1; k <= int'(PulseLen); k++) begin
         step(); exp_busy = 1; exp_conv = 1; check_all(); drive_busy();
      end
      step(); exp_conv = 0; check_all();
      for (int j = 1; j <= int'(ConvTo); j++) begin
         drive_busy(); bus.ready_conv = (j == cd); step(); bus.ready_conv = 1'b0;
         if (j == cd) break;
         if (j == int'(ConvTo)) begin
            exp_to = 1; exp_stage = 2'b01; exp_busy = 0; check_all();
            return;
         end
         check_all();
      end
      for (int k = 1; k <= int'(PulseLen); k++) begin
         if (k > 1) step();
         exp_lag = 1; check_all(); drive_busy();
      end
      step(); exp_lag = 0; check_all();
      for (int j = 1; j <= int'(LagTo); j++) begin
         drive_busy();
         if (j == abort_j) begin
            bus.run = 1'b0;
            bus.sampling_cycle_counter = rand_phase();
         end
         bus.ready_lag = (j == ld); step(); bus.ready_lag = 1'b0;
         if (j == abort_j) begin
            check_all(); bus.run = 1'b1;
            return;
         end
         if (j == ld) break;
         if (j == int'(LagTo)) begin
            exp_to = 1; exp_stage = 2'b10; exp_busy = 0; check_all();
            return;
         end
         check_all();
      end
      check_all(); drive_busy(); step();
      exp_busy = 0; exp_fc++; warm++;
      if (warm == int'(Warmup)) warm_at = cyc;
      if (out_rise < 0) out_rise = cyc;
      check_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int cd, ld, ab;
      bus.run = 1'b0;
      bus.sampling_cycle_counter = '1;
      bus.ready_conv = 1'b0;
      bus.ready_lag  = 1'b0;
      bus.clear_err  = 1'b0;
      model_reset();
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b1;
      bus.run = 1'b1;
      repeat (3) idle_tick();

      // Nominal frames: enable_out after frame 1, lag_sampling_en after frame 2.
      frame(10, 100, 0);
      repeat (3) idle_tick();
      frame(10, 100, 0);
      repeat (60) idle_tick();

      // Conv timeout, then a clear.
      frame(0, 5, 0);
      frame(3, 5, 0);
      bus.clear_err = 1'b1; step(); bus.clear_err = 1'b0; check_all();

      // Lag ready coinciding with the limit wins; one edge later is a timeout.
      frame(3, LagTo, 0);
      idle_tick();
      frame(3, LagTo + 1, 0);
      idle_tick();

      // Overrun-heavy frames and an abort mid lag-wait.
      ov_rate = 6;
      frame(5, 40, 0);
      frame(5, 40, 0);
      frame(2, 0, 7);
      repeat (3) idle_tick();

      ov_rate = 30;
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(4, 1)) idle_tick();
         if ($urandom_range(9) == 0) run_low($urandom_range(3, 1));
         case ($urandom_range(4))
            0:       cd = ConvTo;
            1:       cd = ConvTo + 1;
            2:       cd = 0;
            default: cd = $urandom_range(ConvTo - 1, 1);
         endcase
         case ($urandom_range(4))
            0:       ld = LagTo;
            1:       ld = LagTo + 1;
            default: ld = $urandom_range(40, 1);
         endcase
         ab = ($urandom_range(9) == 0) ? $urandom_range(10, 1) : 0;
         frame(cd, ld, ab);
      end
      repeat (3) idle_tick();

      // Asynchronous reset in the middle of a conv pulse.
      ov_rate = 0;
      bus.sampling_cycle_counter = '0;
      step(); exp_busy = 1; exp_conv = 1; check_all();
      bus.sampling_cycle_counter = rand_phase();
      step(); check_all();
      #3 rst = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      cyc++;
      rst = 1'b1;
      check_all();
      repeat (2) idle_tick();
      frame(4, 8, 0);
      repeat (2) idle_tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/echo_frame_sequencer.md
Name: echo_frame_sequencer

Overview:
Per-sample-frame controller for the echo-cancellation chain. It sequences the enables of the 16b-to-double converter, the lag generator, both double-to-16b converters and the echo canceller, using their ready handshakes instead of fixed delays. It detects frames that time out or overrun, and gates lag-generator sampling until a warm-up period has elapsed. It sits between the sampling-cycle counter and the datapath modules, replacing hand-timed enable sequencing.

Parameters:
PULSE_LEN, 4, cycles each enable pulse (enable_conv, enable_lag) stays high; the double-operation length.
CONV_TIMEOUT, 64, max cycles to wait for ready_conv after the conv pulse ends.
LAG_TIMEOUT, 1024, max cycles to wait for ready_lag after the lag pulse ends.
CANCEL_DELAY, 2500, cycles from enable_out rising to enable_cancel rising.
WARMUP_FRAMES, 2, completed frames before lag_sampling_en asserts.
CW, 13, width of sampling_cycle_counter.

Ports:
clk_operation  in  1  operation clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  global run; low aborts and idles the sequencer
sampling_cycle_counter  in  CW  frame phase; value 0 marks frame start
ready_conv  in  1  converter result valid
ready_lag  in  1  lag generator result valid
clear_err  in  1  synchronous clear of sticky error flags
enable_conv  out  1  converter enable pulse
enable_lag  out  1  lag generator enable pulse
enable_out  out  1  level enable for both double-to-16b converters
enable_cancel  out  1  level enable for echo canceller
lag_sampling_en  out  1  lag generator sampling enable
frame_count  out  16  completed-frame counter, wraps 0xFFFF->0
timeout_err  out  1  sticky: a ready timed out
err_stage  out  2  last timeout source: 01 conv, 10 lag, 00 none
overrun_err  out  1  sticky: frame start arrived while busy
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): every output 0, state IDLE, all internal counters 0.
- All outputs are registered.
- IDLE: if run=1 and sampling_cycle_counter==0, go to CONV_PULSE on the next edge.
- CONV_PULSE: enable_conv=1 for exactly PULSE_LEN cycles, beginning the cycle after frame start is detected. Then go to CONV_WAIT with the wait counter at 0.
- CONV_WAIT: if ready_conv=1, go to LAG_PULSE. Else increment the wait counter; when it reaches CONV_TIMEOUT, set timeout_err=1 and err_stage=01, then go to IDLE (frame aborted, frame_count unchanged). If ready and the limit coincide, ready wins.
- LAG_PULSE: enable_lag=1 for PULSE_LEN cycles, then go to LAG_WAIT.
- LAG_WAIT: same rules as CONV_WAIT, using ready_lag, LAG_TIMEOUT and err_stage=10. On ready, go to FRAME_DONE.
- FRAME_DONE (1 cycle):
  - Increment frame_count.
  - Set enable_out=1 if not already set. This starts the CANCEL_DELAY counter.
  - Return to IDLE.
- enable_cancel rises exactly CANCEL_DELAY cycles after enable_out rises. The delay counter runs independently of the frame FSM.
- enable_out and enable_cancel are levels. They clear only on run=0 or reset.
- lag_sampling_en rises in the cycle after frame_count first reaches WARMUP_FRAMES. It stays high until run=0 or reset.
- Overrun: sampling_cycle_counter==0 while state != IDLE sets overrun_err. The current frame continues; that frame start is dropped.
- run=0 in any state:
  - Next edge: state IDLE; enable_conv, enable_lag, enable_out, enable_cancel and lag_sampling_en all 0; delay and warm-up tracking reset.
  - frame_count and error flags are held.
- clear_err=1 clears timeout_err, err_stage and overrun_err. If a new error fires in the same cycle, the new error wins.
- A frame start in the FRAME_DONE cycle counts as an overrun.

Test Plan:
- Nominal: sampling_cycle=200, run=1, ready_conv 10 cycles after the conv pulse, ready_lag 100 cycles after the lag pulse. Expect:
  - enable_conv high cycles 1-4 after counter==0;
  - enable_lag 4-cycle pulse;
  - frame_count 1 per frame;
  - enable_out set after frame 1;
  - lag_sampling_en set after frame 2.
- Cancel delay: CANCEL_DELAY=50 -> enable_cancel rises exactly 50 cycles after enable_out.
- Conv timeout: ready_conv never asserted -> timeout_err=1 and err_stage=01 at CONV_TIMEOUT; frame_count unchanged; next frame start accepted. clear_err -> flags 0.
- Lag timeout with coincident ready: ready_lag at exactly wait count LAG_TIMEOUT -> frame completes, no error. ready_lag one cycle later -> err_stage=10.
- Overrun: sampling_cycle=20, ready_lag delayed 40 cycles -> overrun_err=1; frame_count still increments once per completed frame.
- Aborts:
  - run=0 mid-LAG_WAIT -> all enables 0 next cycle and state IDLE.
  - rst=0 asynchronously mid-pulse -> outputs 0 immediately, before the next clock edge.
